lif_neuron: RTL and testbench
=============================

LIF_NEURON -- requirements
Module: lif_neuron

Interface
REQ-001 Parameter WIDTH, default 8, bit width of i_ext, thresh, voltage and the membrane register.
REQ-002 Parameter TAU_W, default 4, bit width of tau.
REQ-003 Parameter REFRACT, default 2, refractory length in clock cycles after a spike.
REQ-004 Parameter V_REST, default 0, resting/reset membrane value.
REQ-005 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port i_ext  input  WIDTH  unsigned input current added each integrating cycle.
REQ-008 Port thresh  input  WIDTH  unsigned firing threshold.
REQ-009 Port tau  input  TAU_W  leak shift amount; 0 disables leak.
REQ-010 Port spike  output  1  registered one-cycle spike pulse.
REQ-011 Port voltage  output  WIDTH  registered membrane value.

Function
REQ-012 The block SHALL hold unsigned membrane state v (WIDTH bits), driven directly on voltage.
REQ-013 The block SHALL hold a refractory down-counter r, wide enough for REFRACT; inputs are sampled every edge.
REQ-014 When r>0, each edge SHALL set v=V_REST, r=r-1, spike=0, ignoring i_ext.
REQ-015 When r=0, the block SHALL compute leak = (tau==0) ? 0 : (v >> tau), logical shift; tau >= WIDTH gives leak 0.
REQ-016 When r=0, it SHALL compute sum = v - leak + i_ext in WIDTH+1 bits; v - leak never underflows.
REQ-017 The block SHALL saturate: v_next = min(sum, 2^WIDTH-1).
REQ-018 If v_next >= thresh (unsigned), the edge SHALL set spike=1, v=V_REST, r=REFRACT.
REQ-019 Otherwise the edge SHALL set spike=0, v=v_next, r unchanged (0).
REQ-020 spike SHALL be high for exactly one cycle per firing; REFRACT=0 permits back-to-back spikes.
REQ-021 thresh=0 SHALL cause a spike on every non-refractory cycle.
REQ-022 Input changes SHALL take effect on the next edge with no pipeline delay; v and r are not cleared on input changes.
REQ-023 The comparison SHALL use the saturated v_next, so thresh=2^WIDTH-1 is reachable.

Reset
REQ-024 While reset=1 at an edge: v=V_REST, r=0, spike=0, voltage=V_REST.
REQ-025 Reset SHALL override all other behaviour, including mid-refractory and a same-cycle threshold crossing.
REQ-026 The first integrating edge SHALL be the first edge with reset=0.

Verification
REQ-027 Defaults, tau=0, thresh=20, i_ext=10 after reset: voltage 10, then spike=1 with voltage 0, then 2 refractory cycles at 0; period 4 cycles.
REQ-028 tau=0, thresh=20, i_ext=4: voltage 4, 8, 12, 16, then spike; period 7 cycles. With i_ext=1: 19 ramps then spike; period 22 cycles.
REQ-029 tau=2, thresh=20, i_ext=10: voltage 10, 18, then spike when 24>=20; voltage returns to 0.
REQ-030 tau=0, thresh=255, i_ext=200: voltage 200, then saturates at 255, which is >=255, so spike.
REQ-031 Reset asserted one cycle after a spike (r=1): next edge gives voltage 0, spike 0, r 0; after release, integration starts on the first edge.
REQ-032 thresh=0, i_ext=0, REFRACT=0: spike=1 on every edge after reset; voltage stays 0.

Source files
------------

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: a saturating membrane accumulator with a shift-based leak,
// a threshold spike, and a refractory hold-off counter.
module lif_neuron #(
  parameter int WIDTH   = 8,
  parameter int TAU_W   = 4,
  parameter int REFRACT = 2,
  parameter int V_REST  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_ext,
  input  logic [WIDTH-1:0] thresh,
  input  logic [TAU_W-1:0] tau,
  output logic             spike,
  output logic [WIDTH-1:0] voltage
);

  localparam int R_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [WIDTH-1:0] V_RST  = WIDTH'(V_REST);
  localparam logic [R_W-1:0]   R_LOAD = R_W'(REFRACT);

  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] leak;
  logic [WIDTH-1:0] v_next;
  logic [WIDTH:0]   sum;
  logic [R_W-1:0]   r;

  // Shifts of WIDTH or more naturally yield zero leak; leak <= v so the subtraction cannot wrap.
  always_comb begin
    leak = '0;
    if (tau != '0) leak = v >> tau;
    sum    = {1'b0, v} - {1'b0, leak} + {1'b0, i_ext};
    v_next = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v     <= V_RST;
      r     <= '0;
      spike <= 1'b0;
    end else if (r != '0) begin
      v     <= V_RST;
      r     <= r - R_W'(1);
      spike <= 1'b0;
    end else if (v_next >= thresh) begin
      v     <= V_RST;
      r     <= R_LOAD;
      spike <= 1'b1;
    end else begin
      v     <= v_next;
      spike <= 1'b0;
    end
  end

  assign voltage = v;

endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: directed scenarios with hand-derived traces, a randomized run
// scored against a behavioural model through an expected queue, and a REFRACT=0 instance.
module tb_lif_neuron;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] i_ext;
  logic [7:0] thresh;
  logic [3:0] tau;
  logic       spike;
  logic [7:0] voltage;

  logic       reset0;
  logic [7:0] i_ext0;
  logic [7:0] thresh0;
  logic [3:0] tau0;
  logic       spike0;
  logic [7:0] voltage0;

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] exp_q[$];

  // behavioural model state
  int m_v = 0;
  int m_r = 0;

  always #5 clk = ~clk;

  lif_neuron dut (
    .clk(clk), .reset(reset), .i_ext(i_ext), .thresh(thresh), .tau(tau),
    .spike(spike), .voltage(voltage)
  );

  lif_neuron #(.REFRACT(0)) dut0 (
    .clk(clk), .reset(reset0), .i_ext(i_ext0), .thresh(thresh0), .tau(tau0),
    .spike(spike0), .voltage(voltage0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance the model by one edge using the current inputs and return the expected outputs.
  task automatic model_step(output logic s_o, output logic [7:0] v_o);
    int leak;
    int sum;
    s_o = 1'b0;
    if (reset) begin
      m_v = 0;
      m_r = 0;
    end else if (m_r > 0) begin
      m_v = 0;
      m_r = m_r - 1;
    end else begin
      leak = (tau == 0 || tau >= 8) ? 0 : (m_v / (1 << tau));
      sum  = m_v - leak + int'(i_ext);
      if (sum > 255) sum = 255;
      if (sum >= int'(thresh)) begin
        s_o = 1'b1;
        m_v = 0;
        m_r = 2;
      end else begin
        m_v = sum;
      end
    end
    v_o = 8'(m_v);
  endtask

  // One clock: push the model's prediction, let the DUT take the edge, pop and compare.
  task automatic step(output logic s_o, output logic [7:0] v_o);
    logic       es;
    logic [7:0] ev;
    logic [8:0] got;
    logic [8:0] exp;
    model_step(es, ev);
    exp_q.push_back({es, ev});
    @(posedge clk);
    #1;
    got = {spike, voltage};
    exp = exp_q.pop_front();
    check("scoreboard", 32'(got), 32'(exp));
    s_o = spike;
    v_o = voltage;
  endtask

  // Step once and also compare against a hand-derived constant.
  task automatic expect_out(input string tag, input int ev, input int es);
    logic       s;
    logic [7:0] v;
    step(s, v);
    check({tag, "_v"}, 32'(v), 32'(ev));
    check({tag, "_s"}, 32'(s), 32'(es));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    expect_out("reset", 0, 0);
    reset = 1'b0;
  endtask

  task automatic set_in(input int i, input int th, input int t);
    i_ext  = 8'(i);
    thresh = 8'(th);
    tau    = 4'(t);
  endtask

  initial begin
    logic       s;
    logic [7:0] v;
    int         first;
    reset = 1'b1; i_ext = '0; thresh = '0; tau = '0;
    reset0 = 1'b1; i_ext0 = '0; thresh0 = '0; tau0 = '0;
    @(posedge clk); #1;

    // basic firing: period 4
    set_in(10, 20, 0);
    do_reset();
    expect_out("p4_a", 10, 0);
    expect_out("p4_b", 0, 1);
    expect_out("p4_c", 0, 0);
    expect_out("p4_d", 0, 0);
    expect_out("p4_e", 10, 0);
    expect_out("p4_f", 0, 1);

    // slower ramp: period 7
    set_in(4, 20, 0);
    do_reset();
    expect_out("p7_a", 4, 0);
    expect_out("p7_b", 8, 0);
    expect_out("p7_c", 12, 0);
    expect_out("p7_d", 16, 0);
    expect_out("p7_e", 0, 1);
    expect_out("p7_f", 0, 0);
    expect_out("p7_g", 0, 0);
    expect_out("p7_h", 4, 0);

    // i_ext=1: 19 ramps then a spike on edge 20, next ramp on edge 23
    set_in(1, 20, 0);
    do_reset();
    first = -1;
    for (int k = 1; k <= 30; k++) begin
      step(s, v);
      if (s && first < 0) first = k;
      if (k == 19) check("ramp19_v", 32'(v), 32'd19);
      if (k == 23) check("ramp23_v", 32'(v), 32'd1);
    end
    check("ramp_first_spike", 32'(first), 32'd20);

    // leak with tau=2
    set_in(10, 20, 2);
    do_reset();
    expect_out("leak_a", 10, 0);
    expect_out("leak_b", 18, 0);
    expect_out("leak_c", 0, 1);

    // tau beyond WIDTH means no leak
    set_in(10, 200, 9);
    do_reset();
    expect_out("bigtau_a", 10, 0);
    expect_out("bigtau_b", 20, 0);
    tau = 4'd15;
    expect_out("bigtau_c", 30, 0);

    // saturation reaches thresh=255
    set_in(200, 255, 0);
    do_reset();
    expect_out("sat_a", 200, 0);
    expect_out("sat_b", 0, 1);

    // reset mid-refractory clears r
    set_in(10, 20, 0);
    do_reset();
    expect_out("rref_a", 10, 0);
    expect_out("rref_b", 0, 1);
    expect_out("rref_c", 0, 0);
    reset = 1'b1;
    expect_out("rref_rst", 0, 0);
    reset = 1'b0;
    expect_out("rref_d", 10, 0);
    expect_out("rref_e", 0, 1);

    // reset beats a same-cycle threshold crossing
    expect_out("rx_a", 0, 0);
    expect_out("rx_b", 0, 0);
    expect_out("rx_c", 10, 0);
    reset = 1'b1;
    expect_out("rx_rst", 0, 0);
    reset = 1'b0;
    expect_out("rx_d", 10, 0);

    // randomized run against the model
    for (int n = 0; n < 400; n++) begin
      reset  = ($urandom_range(0, 29) == 0);
      i_ext  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      thresh = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      tau    = 4'($urandom_range(0, 15));
      step(s, v);
    end
    reset = 1'b0;
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    // REFRACT=0 with thresh=0, i_ext=0: spike on every edge, voltage stays 0
    @(posedge clk); #1;
    check("r0_reset_s", 32'(spike0), 32'd0);
    check("r0_reset_v", 32'(voltage0), 32'd0);
    reset0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("r0_spike", 32'(spike0), 32'd1);
      check("r0_volt", 32'(voltage0), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
